// File: rtl/cfir_interp_polyphase_pkg.sv
// Shared types and constants for the polyphase interpolate-by-4 FIR stage.
// Saturation of the shifted result is enabled with `define CFIR_INTERP_SAT_EN.
package cfir_interp_pkg;

  localparam int DW_DEFAULT   = 10;
  localparam int CW_DEFAULT   = 10;
  localparam int TAPS_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  // Linear interpolator, Q1.8: phase p, tap k lives at bit (p*TAPS+k)*CW.
  localparam logic [4*TAPS_DEFAULT*CW_DEFAULT-1:0] COEFS_DEFAULT = {
    10'd0, 10'd0, 10'd192, 10'd64,
    10'd0, 10'd0, 10'd128, 10'd128,
    10'd0, 10'd0, 10'd64,  10'd192,
    10'd0, 10'd0, 10'd0,   10'd256
  };

  function automatic int frac_bits(input int cw);
    return cw - 2;
  endfunction

  function automatic int round_bias(input int cw);
    return 1 << (cw - 3);
  endfunction

endpackage

// File: rtl/cfir_interp_polyphase_if.sv
// Sample input / parallel phase output bundle of the interpolator.
// Handshake: din is taken on a cycle with din_valid high only when the stage can accept it (no backpressure; a refused sample sets overrun); load is a one-cycle strobe marking all four dout words new.
interface cfir_interp_polyphase_if
  import cfir_interp_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) ();
  logic signed [DW-1:0] din;
  logic                 din_valid;
  logic signed [DW-1:0] dout0;
  logic signed [DW-1:0] dout1;
  logic signed [DW-1:0] dout2;
  logic signed [DW-1:0] dout3;
  logic                 load;
  logic                 busy;
  logic                 overrun;
  state_e               state;

  modport master (
    output din, din_valid,
    input  dout0, dout1, dout2, dout3, load, busy, overrun, state
  );

  modport slave (
    input  din, din_valid,
    output dout0, dout1, dout2, dout3, load, busy, overrun, state
  );
endinterface

// File: rtl/cfir_interp_polyphase_mac.sv
// Combinational multiply-accumulate for one interpolation phase, with round-half-up.
// `define CFIR_INTERP_SAT_EN saturates the result; otherwise it wraps to DW bits.
module cfir_phase_mac
  import cfir_interp_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int CW   = CW_DEFAULT,
  parameter int TAPS = TAPS_DEFAULT,
  parameter logic [4*TAPS*CW-1:0] COEFS = COEFS_DEFAULT
) (
   input  logic [1:0]                phase,
   input  logic [TAPS-1:0][DW-1:0]   taps,
   output logic signed [DW-1:0]      y
);
   localparam int PW = DW + CW;
   localparam int AW = DW + CW + $clog2(TAPS);

   logic signed [CW-1:0] c;
   logic signed [DW-1:0] xk;
   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] rounded;

   always_comb begin
      c    = '0;
      xk   = '0;
      prod = '0;
      acc  = '0;
      for (int k = 0; k < TAPS; k++) begin
         c    = $signed(COEFS[(int'(phase) * TAPS + k) * CW +: CW]);
         xk   = $signed(taps[k]);
         prod = PW'(c) * PW'(xk);
         acc  = acc + AW'(prod);
      end
      rounded = acc + AW'(round_bias(CW));
   end

`ifdef CFIR_INTERP_SAT_EN
   localparam logic signed [AW-1:0] YMAX = AW'(2 ** (DW - 1) - 1);
   localparam logic signed [AW-1:0] YMIN = -AW'(2 ** (DW - 1));

   logic signed [AW-1:0] shifted;

   always_comb begin
      shifted = rounded >>> frac_bits(CW);
      if (shifted > YMAX)      y = YMAX[DW-1:0];
      else if (shifted < YMIN) y = YMIN[DW-1:0];
      else                     y = shifted[DW-1:0];
   end
`else
   always_comb begin
      y = DW'(rounded >>> frac_bits(CW));
   end
`endif

endmodule

// File: rtl/cfir_interp_polyphase.sv
// Polyphase interpolate-by-4 FIR: one sample in per 4 clocks, four phase words out on load.
// Result saturation is selected with `define CFIR_INTERP_SAT_EN (wraps when undefined).
module cfir_interp_polyphase
  import cfir_interp_pkg::*;
#(
   parameter int DW   = DW_DEFAULT,
   parameter int CW   = CW_DEFAULT,
   parameter int TAPS = TAPS_DEFAULT,
   parameter logic [4*TAPS*CW-1:0] COEFS = COEFS_DEFAULT
) (
   input  logic                   CLK,
   input  logic                   Reset_n,
   cfir_interp_polyphase_if.slave bus
);
   state_e                  state;
   state_e                  state_nxt;
   logic [1:0]              phase;
   logic [TAPS-1:0][DW-1:0] xline;
   logic signed [DW-1:0]    stage0;
   logic signed [DW-1:0]    stage1;
   logic signed [DW-1:0]    stage2;
   logic signed [DW-1:0]    y;
   logic                    busy;
   logic                    last;
   logic                    accept;
   logic                    drop;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.din_valid) state_nxt = CALC;
         CALC:    if (phase == 2'd3 && !bus.din_valid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A new sample is only taken when no phase computation would be disturbed.
   always_comb begin
      busy   = (state == CALC);
      last   = busy && (phase == 2'd3);
      accept = bus.din_valid && (!busy || phase == 2'd3);
      drop   = bus.din_valid && busy && (phase != 2'd3);
   end

   assign bus.busy  = busy;
   assign bus.state = state;

   cfir_phase_mac #(
      .DW    (DW),
      .CW    (CW),
      .TAPS  (TAPS),
      .COEFS (COEFS)
   ) u_mac (
      .phase (phase),
      .taps  (xline),
      .y     (y)
   );

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         phase       <= '0;
         xline       <= '0;
         stage0      <= '0;
         stage1      <= '0;
         stage2      <= '0;
         bus.dout0   <= '0;
         bus.dout1   <= '0;
         bus.dout2   <= '0;
         bus.dout3   <= '0;
         bus.load    <= 1'b0;
         bus.overrun <= 1'b0;
      end else begin
         bus.load <= last;
         if (drop) bus.overrun <= 1'b1;
         if (accept) begin
            xline <= {xline[TAPS-2:0], bus.din};
            phase <= '0;
         end else if (busy) begin
            phase <= phase + 2'd1;
         end
         if (busy) begin
            case (phase)
               2'd0:    stage0 <= y;
               2'd1:    stage1 <= y;
               2'd2:    stage2 <= y;
               default: ;
            endcase
         end
         // All four words update together with load so the serializer never sees a mix.
         if (last) begin
            bus.dout3 <= stage0;
            bus.dout2 <= stage1;
            bus.dout1 <= stage2;
            bus.dout0 <= y;
         end
      end
   end

endmodule
